uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with fractional baud compensation and an idle-time
// passthrough of a second serial source.
module uart_tx #(
    parameter int CLK_RATE  = 100 * 10 ** 6,
    parameter int BAUD_RATE = 115200
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic       TX_START_I,
    input  logic [7:0] DATA_I,
    output logic       TX_READY_O,
    output logic       TX_DONE_O,
    output logic       TX_O,
    input  logic       CHANNEL_I,
    input  logic       TX2_I
);

    localparam int BIT_INTERVAL       = CLK_RATE / BAUD_RATE;
    localparam int REMAINDER_INTERVAL = ((CLK_RATE % BAUD_RATE) * 10) / BAUD_RATE;
    localparam int REM_DIV            = (REMAINDER_INTERVAL > 0) ? REMAINDER_INTERVAL : 1;
    localparam int BAUD_W             = $clog2(BIT_INTERVAL + 1);
    localparam logic [BAUD_W-1:0] LAST_SHORT = BAUD_W'(BIT_INTERVAL - 1);
    localparam logic [BAUD_W-1:0] LAST_LONG  = BAUD_W'(BIT_INTERVAL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_r;
    logic [3:0]          bit_cnt_r;
    logic [BAUD_W-1:0]   baud_cnt_r;
    logic [7:0]          shift_r;
    logic                tx_r;
    logic                done_r;
    logic                ready_s;
    logic                long_period_s;
    logic                period_end_s;
    logic                tx_s;

    // bit_cnt_r numbers the bit periods 0..9 across the frame, so it also
    // selects which periods get the extra compensation cycle.
    always_comb begin
        long_period_s = 1'b0;
        if (REMAINDER_INTERVAL > 0) begin
            long_period_s = (((int'(bit_cnt_r) + 32'sd1) % REM_DIV) == 32'sd0);
        end else begin
            long_period_s = 1'b0;
        end
        period_end_s = (baud_cnt_r == (long_period_s ? LAST_LONG : LAST_SHORT));
        ready_s      = RST_NI && (state_r == IDLE) && !CHANNEL_I;
    end

    // Frame sequencer: state, counters, latched byte and registered line.
    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 4'd0;
            baud_cnt_r <= '0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    tx_r       <= 1'b1;
                    bit_cnt_r  <= 4'd0;
                    baud_cnt_r <= '0;
                    if (TX_START_I && ready_s) begin
                        state_r <= START;
                        shift_r <= DATA_I;
                        tx_r    <= 1'b0;
                    end
                end
                START: begin
                    if (period_end_s) begin
                        state_r    <= DATA;
                        tx_r       <= shift_r[0];
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= bit_cnt_r + 4'd1;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                DATA: begin
                    if (period_end_s) begin
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd8) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            // bit_cnt_r is one ahead of the data index on the line
                            tx_r <= shift_r[bit_cnt_r[2:0]];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                STOP: begin
                    if (period_end_s) begin
                        state_r    <= IDLE;
                        done_r     <= 1'b1;
                        bit_cnt_r  <= 4'd0;
                        baud_cnt_r <= '0;
                        tx_r       <= 1'b1;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    bit_cnt_r  <= 4'd0;
                    baud_cnt_r <= '0;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

    // Passthrough is only allowed between frames and never during reset.
    always_comb begin
        tx_s = tx_r;
        if (!RST_NI) begin
            tx_s = 1'b1;
        end else if ((state_r == IDLE) && CHANNEL_I) begin
            tx_s = TX2_I;
        end else begin
            tx_s = tx_r;
        end
    end

    assign TX_O       = tx_s;
    assign TX_READY_O = ready_s;
    assign TX_DONE_O  = done_r;

endmodule
